// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the register-file write path
//
// Purpose : holds the output count of the write-data demultiplexer and derives
//           the selector width from it, so both live in one place.
// Contents: NUM_OUTPUTS, SEL_WIDTH, CeilLog2()
package regfile_pkg;

    // Smallest r such that 2**r >= n; returns 0 for n <= 1.
    function automatic int CeilLog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int NUM_OUTPUTS = 32;
    localparam int SEL_WIDTH   = CeilLog2(NUM_OUTPUTS);

endpackage

// File: rtl/decoder_5to32.sv
// rtl/decoder_5to32.sv - combinational binary-to-one-hot select decoder
//
// Purpose : turns the 5-bit register index into a 32-bit one-hot select vector.
// Ports   : sel_i    [SEL_WIDTH-1:0]   binary index 0..NUM_OUTPUTS-1
//           onehot_o [NUM_OUTPUTS-1:0] bit sel_i set, all others clear
module decoder_5to32
    import regfile_pkg::*;
(
    input  logic [SEL_WIDTH-1:0]   sel_i,
    output logic [NUM_OUTPUTS-1:0] onehot_o
);

    // Every code of sel_i maps to a real output, so no out-of-range handling.
    assign onehot_o = {{(NUM_OUTPUTS-1){1'b0}}, 1'b1} << sel_i;

endmodule

// File: rtl/demux_1to32.sv
// rtl/demux_1to32.sv - registered 1-to-32 word demultiplexer for the register-file write path
//
// Purpose : each clock edge routes Demux_Input to the output chosen by Selector;
//           every other output loads 0. One cycle of latency, async active-low clear.
// Ports   : clk                     rising-edge clock
//           reset                   asynchronous active-low clear of all outputs
//           Demux_Input [WL-1:0]    word to route
//           Selector    [4:0]       index of the output that receives the word
//           Data_0..Data_31 [WL-1:0] routed outputs, each straight from its own register
module demux_1to32
    import regfile_pkg::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WORD_LENGTH-1:0] Demux_Input,
    input  logic [SEL_WIDTH-1:0]   Selector,
    output logic [WORD_LENGTH-1:0] Data_0,
    output logic [WORD_LENGTH-1:0] Data_1,
    output logic [WORD_LENGTH-1:0] Data_2,
    output logic [WORD_LENGTH-1:0] Data_3,
    output logic [WORD_LENGTH-1:0] Data_4,
    output logic [WORD_LENGTH-1:0] Data_5,
    output logic [WORD_LENGTH-1:0] Data_6,
    output logic [WORD_LENGTH-1:0] Data_7,
    output logic [WORD_LENGTH-1:0] Data_8,
    output logic [WORD_LENGTH-1:0] Data_9,
    output logic [WORD_LENGTH-1:0] Data_10,
    output logic [WORD_LENGTH-1:0] Data_11,
    output logic [WORD_LENGTH-1:0] Data_12,
    output logic [WORD_LENGTH-1:0] Data_13,
    output logic [WORD_LENGTH-1:0] Data_14,
    output logic [WORD_LENGTH-1:0] Data_15,
    output logic [WORD_LENGTH-1:0] Data_16,
    output logic [WORD_LENGTH-1:0] Data_17,
    output logic [WORD_LENGTH-1:0] Data_18,
    output logic [WORD_LENGTH-1:0] Data_19,
    output logic [WORD_LENGTH-1:0] Data_20,
    output logic [WORD_LENGTH-1:0] Data_21,
    output logic [WORD_LENGTH-1:0] Data_22,
    output logic [WORD_LENGTH-1:0] Data_23,
    output logic [WORD_LENGTH-1:0] Data_24,
    output logic [WORD_LENGTH-1:0] Data_25,
    output logic [WORD_LENGTH-1:0] Data_26,
    output logic [WORD_LENGTH-1:0] Data_27,
    output logic [WORD_LENGTH-1:0] Data_28,
    output logic [WORD_LENGTH-1:0] Data_29,
    output logic [WORD_LENGTH-1:0] Data_30,
    output logic [WORD_LENGTH-1:0] Data_31
);

    logic [NUM_OUTPUTS-1:0] onehot;
    logic [WORD_LENGTH-1:0] data_arr [NUM_OUTPUTS];

    decoder_5to32 u_decoder (
        .sel_i    (Selector),
        .onehot_o (onehot)
    );

    // Selector and Demux_Input are captured on the same edge by every register,
    // so a simultaneous change of both is always seen as one consistent pair.
    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_reg
        logic [WORD_LENGTH-1:0] data_d;
        logic [WORD_LENGTH-1:0] data_q;

        assign data_d = onehot[k] ? Demux_Input : '0;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                data_q <= '0;
            end else begin
                data_q <= data_d;
            end
        end

        assign data_arr[k] = data_q;
    end

    assign Data_0  = data_arr[0];
    assign Data_1  = data_arr[1];
    assign Data_2  = data_arr[2];
    assign Data_3  = data_arr[3];
    assign Data_4  = data_arr[4];
    assign Data_5  = data_arr[5];
    assign Data_6  = data_arr[6];
    assign Data_7  = data_arr[7];
    assign Data_8  = data_arr[8];
    assign Data_9  = data_arr[9];
    assign Data_10 = data_arr[10];
    assign Data_11 = data_arr[11];
    assign Data_12 = data_arr[12];
    assign Data_13 = data_arr[13];
    assign Data_14 = data_arr[14];
    assign Data_15 = data_arr[15];
    assign Data_16 = data_arr[16];
    assign Data_17 = data_arr[17];
    assign Data_18 = data_arr[18];
    assign Data_19 = data_arr[19];
    assign Data_20 = data_arr[20];
    assign Data_21 = data_arr[21];
    assign Data_22 = data_arr[22];
    assign Data_23 = data_arr[23];
    assign Data_24 = data_arr[24];
    assign Data_25 = data_arr[25];
    assign Data_26 = data_arr[26];
    assign Data_27 = data_arr[27];
    assign Data_28 = data_arr[28];
    assign Data_29 = data_arr[29];
    assign Data_30 = data_arr[30];
    assign Data_31 = data_arr[31];

endmodule

// File: tb/tb_demux_1to32.sv
// tb/tb_demux_1to32.sv - directed self-checking bench for demux_1to32
module tb_demux_1to32;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic [4:0]  sel;
    logic [31:0] dout [32];

    int checks;
    int errors;

    typedef struct {
        logic [4:0]  sel;
        logic [31:0] din;
        int          exp_idx;
        logic [31:0] exp_val;
        string       name;
    } vec_t;

    vec_t vecs [8];

    demux_1to32 #(.WORD_LENGTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .Demux_Input (din),
        .Selector    (sel),
        .Data_0  (dout[0]),  .Data_1  (dout[1]),  .Data_2  (dout[2]),  .Data_3  (dout[3]),
        .Data_4  (dout[4]),  .Data_5  (dout[5]),  .Data_6  (dout[6]),  .Data_7  (dout[7]),
        .Data_8  (dout[8]),  .Data_9  (dout[9]),  .Data_10 (dout[10]), .Data_11 (dout[11]),
        .Data_12 (dout[12]), .Data_13 (dout[13]), .Data_14 (dout[14]), .Data_15 (dout[15]),
        .Data_16 (dout[16]), .Data_17 (dout[17]), .Data_18 (dout[18]), .Data_19 (dout[19]),
        .Data_20 (dout[20]), .Data_21 (dout[21]), .Data_22 (dout[22]), .Data_23 (dout[23]),
        .Data_24 (dout[24]), .Data_25 (dout[25]), .Data_26 (dout[26]), .Data_27 (dout[27]),
        .Data_28 (dout[28]), .Data_29 (dout[29]), .Data_30 (dout[30]), .Data_31 (dout[31])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp_idx < 0 means every output is expected to read 0.
    task automatic check_all(input string name, input int exp_idx, input logic [31:0] exp_val);
        logic [31:0] exp;
        for (int k = 0; k < 32; k++) begin
            exp = (k == exp_idx) ? exp_val : 32'd0;
            checks++;
            if (dout[k] !== exp) begin
                errors++;
                $display("FAIL %s Data_%0d got %h expected %h", name, k, dout[k], exp);
            end
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic [4:0] s, input logic [31:0] d);
        @(negedge clk);
        sel = s;
        din = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sel    = 5'd3;
        din    = 32'd25;

        vecs[0] = '{5'd3,  32'd25,          3,  32'd25,          "route_sel3"};
        vecs[1] = '{5'd10, 32'd25,          10, 32'd25,          "route_sel10"};
        vecs[2] = '{5'd30, 32'd25,          30, 32'd25,          "route_sel30"};
        vecs[3] = '{5'd0,  32'hFFFFFFFF,    0,  32'hFFFFFFFF,    "boundary_sel0"};
        vecs[4] = '{5'd31, 32'hA5A5A5A5,    31, 32'hA5A5A5A5,    "boundary_sel31"};
        vecs[5] = '{5'd5,  32'd7,           5,  32'd7,           "pair_old"};
        vecs[6] = '{5'd6,  32'd9,           6,  32'd9,           "pair_new"};
        vecs[7] = '{5'd17, 32'd0,           -1, 32'd0,           "zero_input"};

        // Asynchronous clear before any clock edge
        #2 reset = 1'b0;
        #1 check_all("async_reset", -1, 32'd0);

        // Outputs stay cleared across an edge while reset is held low
        @(posedge clk);
        #1 check_all("hold_reset", -1, 32'd0);

        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            step(vecs[i].sel, vecs[i].din);
            check_all(vecs[i].name, vecs[i].exp_idx, vecs[i].exp_val);
        end

        // Sweep every selector code
        for (int k = 0; k < 32; k++) begin
            step(5'(k), 32'(100 + k));
            check_all("sweep", k, 32'(100 + k));
        end

        // Mid-operation reset between edges, then normal reload
        step(5'd12, 32'd55);
        check_all("pre_reset_12", 12, 32'd55);
        #2 reset = 1'b0;
        #1 check_all("mid_reset", -1, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        sel   = 5'd12;
        din   = 32'd56;
        @(posedge clk);
        #1 check_all("reload_after_reset", 12, 32'd56);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
